if_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline; directly upstream of the ID stage and the hazard unit.
- Owns the PC and issues single-outstanding requests to a variable-latency instruction memory.
- Buffers one returned instruction and presents Instr_ID/PC_ID to decode.
- Honours Stall from the hazard unit and applies branch/jump redirects from ID with one architectural delay slot.

---
 rtl/if_stage_if.sv | 22 ++
 rtl/if_stage.sv | 127 ++++++++++++
 tb/tb_if_stage.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
// Single outstanding request: im_req/im_addr hold until im_ack returns im_rdata.
interface if_stage_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;

    modport master (
        output im_req,
        output im_addr,
        input  im_ack,
        input  im_rdata
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ack,
        output im_rdata
    );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage with IF/ID pipeline register, a one-entry return buffer for
// stalls, and delayed-branch redirect handling (one architectural delay slot).
module if_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Stall,
    input  logic        NPC_Sel,
    input  logic [31:0] NPC_Target,
    if_stage_if.master  im,
    output logic [31:0] Instr_ID,
    output logic [31:0] PC_ID,
    output logic [31:0] PC8_ID,
    output logic        Valid_ID
);

    typedef enum logic [0:0] {StReq, StFull} state_e;

    state_e      state_q;
    logic        im_req_q;
    logic [31:0] fetch_pc_q;
    logic        pend_valid_q;
    logic [31:0] pend_target_q;
    logic [31:0] buf_instr_q;
    logic [31:0] buf_pc_q;
    logic [31:0] instr_id_q;
    logic [31:0] pc_id_q;
    logic        valid_id_q;

    logic        adv;
    logic        ack;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] seq_pc;
    logic [31:0] nxt_pc;

    assign adv      = ~Stall;
    // Acks are only meaningful while our request is on the bus; this also drops a stale
    // ack that arrives just after reset.
    assign ack      = im_req_q & im.im_ack;
    assign redirect = NPC_Sel & valid_id_q & adv;
    assign target   = NPC_Target & 32'hFFFF_FFFC;
    assign seq_pc   = fetch_pc_q + 32'd4;

    // A redirect coinciding with the delay-slot ack bypasses the pending register.
    always_comb begin
        if (redirect) begin
            nxt_pc = target;
        end else if (pend_valid_q) begin
            nxt_pc = pend_target_q;
        end else begin
            nxt_pc = seq_pc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StReq;
            im_req_q      <= 1'b0;
            fetch_pc_q    <= PC_RESET;
            pend_valid_q  <= 1'b0;
            pend_target_q <= PC_RESET;
            buf_instr_q   <= NOP_INSTR;
            buf_pc_q      <= PC_RESET;
            instr_id_q    <= NOP_INSTR;
            pc_id_q       <= PC_RESET;
            valid_id_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StReq: begin
                    if (ack) begin
                        fetch_pc_q   <= nxt_pc;
                        pend_valid_q <= 1'b0;
                        if (adv) begin
                            instr_id_q <= im.im_rdata;
                            pc_id_q    <= fetch_pc_q;
                            valid_id_q <= 1'b1;
                        end else begin
                            buf_instr_q <= im.im_rdata;
                            buf_pc_q    <= fetch_pc_q;
                            state_q     <= StFull;
                            im_req_q    <= 1'b0;
                        end
                    end else begin
                        im_req_q <= 1'b1;
                        // Delay slot still in flight: remember where to go after it.
                        if (redirect) begin
                            pend_target_q <= target;
                            pend_valid_q  <= 1'b1;
                        end
                        if (adv) begin
                            instr_id_q <= NOP_INSTR;
                            valid_id_q <= 1'b0;
                        end
                    end
                end
                StFull: begin
                    if (adv) begin
                        instr_id_q <= buf_instr_q;
                        pc_id_q    <= buf_pc_q;
                        valid_id_q <= 1'b1;
                        state_q    <= StReq;
                        im_req_q   <= 1'b1;
                        // Delay slot already buffered, so the target is the very next fetch.
                        if (redirect) begin
                            fetch_pc_q <= target;
                        end
                    end
                end
                default: begin
                    state_q <= StReq;
                end
            endcase
        end
    end

    assign im.im_req  = im_req_q;
    assign im.im_addr = fetch_pc_q;

    assign Instr_ID = instr_id_q;
    assign PC_ID    = pc_id_q;
    assign PC8_ID   = pc_id_q + 32'd8;
    assign Valid_ID = valid_id_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, mid-request reset sequence, and a randomized
// run checked against a queue-based reference model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        Stall = 1'b0;
    logic        NPC_Sel = 1'b0;
    logic [31:0] NPC_Target = 32'h0;
    logic [31:0] Instr_ID;
    logic [31:0] PC_ID;
    logic [31:0] PC8_ID;
    logic        Valid_ID;

    if_stage_if im_bus ();

    if_stage dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Stall      (Stall),
        .NPC_Sel    (NPC_Sel),
        .NPC_Target (NPC_Target),
        .im         (im_bus),
        .Instr_ID   (Instr_ID),
        .PC_ID      (PC_ID),
        .PC8_ID     (PC8_ID),
        .Valid_ID   (Valid_ID)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        stall;
        logic        ack;
        logic        sel;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_t;

    vec_t tbl[$];

    // Reference model state
    bit          m_live;
    logic [31:0] m_fetch;
    logic [31:0] m_pend[$];
    fetch_t      m_buf[$];
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_valid;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hAB00_0000 + a;
    endfunction

    function automatic vec_t v(input logic stall, input logic ack, input logic sel,
                               input logic [31:0] tgt, input logic req, input logic [31:0] addr,
                               input logic [31:0] instr, input logic [31:0] pc,
                               input logic valid);
        vec_t r;
        r.stall = stall; r.ack = ack; r.sel = sel; r.tgt = tgt;
        r.req = req; r.addr = addr; r.instr = instr; r.pc = pc; r.valid = valid;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                             input logic [31:0] instr, input logic [31:0] pc,
                             input logic valid);
        chk({tag, " im_req"},   {31'b0, im_bus.im_req}, {31'b0, req});
        chk({tag, " im_addr"},  im_bus.im_addr, addr);
        chk({tag, " Instr_ID"}, Instr_ID, instr);
        chk({tag, " PC_ID"},    PC_ID, pc);
        chk({tag, " PC8_ID"},   PC8_ID, pc + 32'd8);
        chk({tag, " Valid_ID"}, {31'b0, Valid_ID}, {31'b0, valid});
    endtask

    task automatic drive(input logic stall, input logic ack, input logic sel,
                         input logic [31:0] tgt, input logic [31:0] addr);
        Stall           = stall;
        NPC_Sel         = sel;
        NPC_Target      = tgt;
        im_bus.im_ack   = ack;
        im_bus.im_rdata = ack ? mem(addr) : 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        Stall         = 1'b0;
        NPC_Sel       = 1'b0;
        im_bus.im_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic model_reset();
        m_live  = 1'b0;
        m_fetch = 32'h0000_3000;
        m_pend.delete();
        m_buf.delete();
        m_instr = 32'h0;
        m_pc    = 32'h0000_3000;
        m_valid = 1'b0;
    endtask

    task automatic model_step(input logic stall, input logic ack, input logic sel,
                              input logic [31:0] tgt);
        logic        adv;
        logic        redir;
        logic        take;
        logic [31:0] t;
        logic [31:0] nxt;
        fetch_t      e;
        adv   = !stall;
        redir = sel && m_valid && adv;
        t     = tgt & 32'hFFFF_FFFC;
        take  = ack && m_live && (m_buf.size() == 0);
        if (m_buf.size() == 0) begin
            if (take) begin
                if (redir) nxt = t;
                else if (m_pend.size() > 0) nxt = m_pend[0];
                else nxt = m_fetch + 32'd4;
                m_pend.delete();
                e.instr = mem(m_fetch);
                e.pc    = m_fetch;
                if (adv) begin
                    m_instr = e.instr; m_pc = e.pc; m_valid = 1'b1;
                end else begin
                    m_buf.push_back(e);
                end
                m_fetch = nxt;
            end else begin
                if (redir) begin
                    m_pend.delete();
                    m_pend.push_back(t);
                end
                if (adv) begin
                    m_instr = 32'h0; m_valid = 1'b0;
                end
            end
        end else if (adv) begin
            e = m_buf.pop_front();
            m_instr = e.instr; m_pc = e.pc; m_valid = 1'b1;
            if (redir) m_fetch = t;
        end
        m_live = 1'b1;
    endtask

    initial begin
        logic [31:0] cur_addr;
        logic        st;
        logic        ak;
        logic        sl;
        logic [31:0] tg;
        logic [31:0] ad;

        im_bus.im_ack   = 1'b0;
        im_bus.im_rdata = 32'h0;

        // stall ack sel tgt | req addr instr pc valid
        tbl.push_back(v(0, 0, 0, 32'h0,         1, 32'h3000, 32'h0,         32'h3000, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,         1, 32'h3000, 32'h0,         32'h3000, 0));
        tbl.push_back(v(0, 1, 0, 32'h0,         1, 32'h3004, 32'hAB00_3000, 32'h3000, 1));
        tbl.push_back(v(0, 0, 0, 32'h0,         1, 32'h3004, 32'h0,         32'h3000, 0));
        tbl.push_back(v(0, 1, 0, 32'h0,         1, 32'h3008, 32'hAB00_3004, 32'h3004, 1));
        tbl.push_back(v(0, 0, 1, 32'h3101,      1, 32'h3008, 32'h0,         32'h3004, 0));
        tbl.push_back(v(0, 1, 0, 32'h0,         1, 32'h3100, 32'hAB00_3008, 32'h3008, 1));
        tbl.push_back(v(0, 0, 0, 32'h0,         1, 32'h3100, 32'h0,         32'h3008, 0));
        tbl.push_back(v(0, 1, 0, 32'h0,         1, 32'h3104, 32'hAB00_3100, 32'h3100, 1));
        tbl.push_back(v(1, 1, 0, 32'h0,         0, 32'h3108, 32'hAB00_3100, 32'h3100, 1));
        tbl.push_back(v(1, 0, 0, 32'h0,         0, 32'h3108, 32'hAB00_3100, 32'h3100, 1));
        tbl.push_back(v(0, 0, 0, 32'h0,         1, 32'h3108, 32'hAB00_3104, 32'h3104, 1));
        tbl.push_back(v(0, 0, 0, 32'h0,         1, 32'h3108, 32'h0,         32'h3104, 0));
        tbl.push_back(v(0, 1, 0, 32'h0,         1, 32'h310C, 32'hAB00_3108, 32'h3108, 1));
        tbl.push_back(v(1, 0, 1, 32'h3200,      1, 32'h310C, 32'hAB00_3108, 32'h3108, 1));
        tbl.push_back(v(0, 0, 1, 32'h3200,      1, 32'h310C, 32'h0,         32'h3108, 0));
        tbl.push_back(v(0, 1, 0, 32'h0,         1, 32'h3200, 32'hAB00_310C, 32'h310C, 1));
        tbl.push_back(v(0, 0, 0, 32'h0,         1, 32'h3200, 32'h0,         32'h310C, 0));
        tbl.push_back(v(0, 1, 0, 32'h0,         1, 32'h3204, 32'hAB00_3200, 32'h3200, 1));
        tbl.push_back(v(1, 1, 0, 32'h0,         0, 32'h3208, 32'hAB00_3200, 32'h3200, 1));
        tbl.push_back(v(0, 0, 1, 32'h3300,      1, 32'h3300, 32'hAB00_3204, 32'h3204, 1));
        tbl.push_back(v(0, 1, 0, 32'h0,         1, 32'h3304, 32'hAB00_3300, 32'h3300, 1));
        tbl.push_back(v(0, 1, 1, 32'h3400,      1, 32'h3400, 32'hAB00_3304, 32'h3304, 1));
        tbl.push_back(v(0, 1, 0, 32'h0,         1, 32'h3404, 32'hAB00_3400, 32'h3400, 1));
        tbl.push_back(v(0, 0, 0, 32'h0,         1, 32'h3404, 32'h0,         32'h3400, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,         1, 32'h3404, 32'h0,         32'h3400, 0));
        tbl.push_back(v(0, 0, 0, 32'h0,         1, 32'h3404, 32'h0,         32'h3400, 0));
        tbl.push_back(v(0, 1, 0, 32'h0,         1, 32'h3408, 32'hAB00_3404, 32'h3404, 1));
        tbl.push_back(v(0, 1, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC, 32'hAB00_3408, 32'h3408, 1));
        tbl.push_back(v(0, 1, 0, 32'h0,         1, 32'h0000_0000, 32'hAAFF_FFFC, 32'hFFFF_FFFC, 1));

        do_reset();
        check_all("reset", 1'b0, 32'h3000, 32'h0, 32'h3000, 1'b0);

        cur_addr = 32'h3000;
        foreach (tbl[i]) begin
            drive(tbl[i].stall, tbl[i].ack, tbl[i].sel, tbl[i].tgt, cur_addr);
            check_all($sformatf("tbl%0d", i), tbl[i].req, tbl[i].addr, tbl[i].instr,
                      tbl[i].pc, tbl[i].valid);
            cur_addr = tbl[i].addr;
        end

        // Reset pulsed while the request at 0x3010 is outstanding
        do_reset();
        drive(0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 32'h0, 32'h3000 + 32'(i) * 32'd4);
        end
        check_all("pre_rst", 1'b1, 32'h3010, 32'hAB00_300C, 32'h300C, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 32'h3000, 32'h0, 32'h3000, 1'b0);
        im_bus.im_ack   = 1'b1;
        im_bus.im_rdata = mem(32'h3010);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(0, 1, 0, 32'h0, 32'h3010);
        check_all("stale_ack", 1'b1, 32'h3000, 32'h0, 32'h3000, 1'b0);
        drive(0, 1, 0, 32'h0, 32'h3000);
        check_all("post_rst", 1'b1, 32'h3004, 32'hAB00_3000, 32'h3000, 1'b1);

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(0, 3) == 0);
            ak = (m_live && (m_buf.size() == 0)) ? ($urandom_range(0, 1) == 1) : 1'b0;
            sl = ($urandom_range(0, 5) == 0);
            tg = $urandom;
            if ($urandom_range(0, 9) == 0) tg = 32'hFFFF_FFF0 | (tg & 32'hF);
            ad = m_fetch;
            model_step(st, ak, sl, tg);
            drive(st, ak, sl, tg, ad);
            check_all($sformatf("rnd%0d", i), m_live && (m_buf.size() == 0), m_fetch,
                      m_instr, m_pc, m_valid);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                model_reset();
                check_all($sformatf("rnd_rst%0d", i), 1'b0, 32'h3000, 32'h0, 32'h3000, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
